// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: turns a raw, asynchronous PLL LOCK into a clean
// design reset. LOCK is synchronized, debounced, then reset is held for a
// fixed hold-off before release. Lock losses seen while running are
// counted with a saturating counter. A soft reset re-runs the hold-off.
//
// Ports:
//   clock      : PLL output clock, the only clock
//   reset_n    : asynchronous active-low reset
//   pll_lock   : raw PLL LOCK, asynchronous to clock
//   soft_reset : single-cycle request to re-run hold-off (RUN only)
//   reset      : registered active-high reset for the design
//   ready      : registered, high only in RUN (always ~reset)
//   loss_count : saturating count of lock losses seen in RUN
module pll_reset_sequencer #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES     = 16,
    parameter int unsigned LOSS_W          = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              pll_lock,
    input  logic              soft_reset,
    output logic              reset,
    output logic              ready,
    output logic [LOSS_W-1:0] loss_count
);

    localparam int unsigned CNT_MAX =
        (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

    // Terminal values: the cycle in which the counter holds *_LAST is the
    // final one of the phase, so the transition lands exactly on count N.
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [LOSS_W-1:0] LOSS_MAX = '1;
    localparam logic [LOSS_W-1:0] LOSS_ONE = LOSS_W'(1);

    // A one-cycle debounce is already satisfied by the sample that leaves
    // WAIT_LOCK, so that case skips straight to HOLD.
    localparam logic DEB_SINGLE = (DEBOUNCE_CYCLES == 1);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        DEBOUNCE,
        HOLD,
        RUN
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [LOSS_W-1:0]   loss_q, loss_d;
    logic                reset_q;
    logic                ready_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                lock_s;

    // Lock synchronizer: the only logic that touches pll_lock.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
        end
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            loss_q  <= '0;
            reset_q <= 1'b1;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            loss_q  <= loss_d;
            // Both outputs are decoded from the next state so they
            // change on the same edge as the state itself.
            reset_q <= (state_d != RUN);
            ready_q <= (state_d == RUN);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        loss_d  = loss_q;

        unique case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (lock_s) begin
                    if (DEB_SINGLE) begin
                        state_d = HOLD;
                    end else begin
                        state_d = DEBOUNCE;
                        cnt_d   = CNT_ONE;
                    end
                end
            end

            DEBOUNCE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q >= DEB_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            HOLD: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q >= HOLD_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            RUN: begin
                cnt_d = '0;
                // Lock loss has priority over a simultaneous soft reset.
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    if (loss_q != LOSS_MAX) begin
                        loss_d = loss_q + LOSS_ONE;
                    end
                end else if (soft_reset) begin
                    state_d = HOLD;
                end
            end

            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    assign reset      = reset_q;
    assign ready      = ready_q;
    assign loss_count = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed scenarios plus random lock and
// soft-reset traffic, checked against a cycle-level behavioural model.
module tb_pll_reset_sequencer;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int HOLD = 16;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       pll_lock = 1'b0;
    logic       soft_reset = 1'b0;
    logic       rst_a, rdy_a, rst_b, rdy_b;
    logic [7:0] loss_a;
    logic [1:0] loss_b;
    logic [13:0] obs;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    pll_reset_sequencer #(
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES(HOLD), .LOSS_W(8)
    ) dut_a (
        .clock(clock), .reset_n(reset_n), .pll_lock(pll_lock),
        .soft_reset(soft_reset), .reset(rst_a), .ready(rdy_a),
        .loss_count(loss_a)
    );

    pll_reset_sequencer #(
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES(HOLD), .LOSS_W(2)
    ) dut_b (
        .clock(clock), .reset_n(reset_n), .pll_lock(pll_lock),
        .soft_reset(soft_reset), .reset(rst_b), .ready(rdy_b),
        .loss_count(loss_b)
    );

    assign obs = {rst_a, rdy_a, loss_a, rst_b, rdy_b, loss_b};

    // Reference: lock is seen SYNC edges late (delay line). The design is
    // released once lock has been seen high for DEB+HOLD consecutive
    // edges; a soft reset in RUN credits the debounce and restarts hold.
    bit         m_dly[$];
    int         m_streak = 0;
    bit         m_run = 0;
    logic [7:0] m_loss = '0;
    logic [1:0] m_loss2 = '0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_dly = {};
            for (int k = 0; k < SYNC; k++) m_dly.push_back(1'b0);
            m_streak = 0;
            m_run    = 0;
            m_loss   = '0;
            m_loss2  = '0;
        end else begin
            if (!m_dly[0]) begin
                if (m_run) begin
                    if (m_loss != 8'hFF) m_loss = m_loss + 8'd1;
                    if (m_loss2 != 2'd3) m_loss2 = m_loss2 + 2'd1;
                end
                m_streak = 0;
                m_run    = 0;
            end else if (m_run) begin
                if (soft_reset) begin
                    m_streak = DEB;
                    m_run    = 0;
                end
            end else begin
                m_streak++;
                if (m_streak >= DEB + HOLD) m_run = 1;
            end
            m_dly.push_back(pll_lock);
            void'(m_dly.pop_front());
        end
    end

    function automatic logic [13:0] mexp();
        return {!m_run, m_run, m_loss, !m_run, m_run, m_loss2};
    endfunction

    task automatic apply_reset(input logic lk);
        @(negedge clock);
        reset_n    = 1'b0;
        pll_lock   = lk;
        soft_reset = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic run_to_ready();
        bit got = 0;
        pll_lock   = 1'b1;
        soft_reset = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clock);
            if (rdy_a) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL run_to_ready timeout ready=%b want 1", rdy_a);
        end
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        pll_lock = 1'b1;
        repeat (3) @(negedge clock);
        total++;
        if (obs !== 14'b10_00000000_10_00) begin
            bad++;
            $display("FAIL reset_state got=%b want=%b",
                     obs, 14'b10_00000000_10_00);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_powerup();
        int fall = 0;
        apply_reset(1'b1);
        for (int i = 1; i <= 30; i++) begin
            @(negedge clock);
            total++;
            if (obs !== mexp()) begin
                bad++;
                $display("FAIL powerup cyc=%0d got=%b want=%b",
                         i, obs, mexp());
            end
            if (!rst_a && fall == 0) fall = i;
        end
        total++;
        if (fall !== SYNC + DEB + HOLD) begin
            bad++;
            $display("FAIL powerup_edge got=%0d want=%0d",
                     fall, SYNC + DEB + HOLD);
        end
    endtask

    task automatic test_glitch();
        int fall = 0;
        apply_reset(1'b1);
        repeat (3) @(negedge clock);
        pll_lock = 1'b0;
        @(negedge clock);
        pll_lock = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clock);
            total++;
            if (obs !== mexp()) begin
                bad++;
                $display("FAIL glitch cyc=%0d got=%b want=%b",
                         i, obs, mexp());
            end
            if (!rst_a && fall == 0) fall = i;
        end
        total++;
        if (fall !== 22) begin
            bad++;
            $display("FAIL glitch_edge got=%0d want=22", fall);
        end
    endtask

    task automatic test_loss();
        int rise = 0;
        int fall = 0;
        apply_reset(1'b1);
        run_to_ready();
        pll_lock = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clock);
            total++;
            if (obs !== mexp()) begin
                bad++;
                $display("FAIL loss cyc=%0d got=%b want=%b",
                         i, obs, mexp());
            end
            if (i == 1) pll_lock = 1'b1;
            if (rst_a && rise == 0) rise = i;
            if (!rst_a && rise != 0 && fall == 0) fall = i;
        end
        total++;
        if (rise !== 3 || fall !== 23 || loss_a !== 8'd1) begin
            bad++;
            $display("FAIL loss_timing got rise=%0d fall=%0d loss=%0d want 3 23 1",
                     rise, fall, loss_a);
        end
    endtask

    task automatic test_soft();
        int hi = 0;
        apply_reset(1'b1);
        run_to_ready();
        soft_reset = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            @(negedge clock);
            total++;
            if (obs !== mexp()) begin
                bad++;
                $display("FAIL soft cyc=%0d got=%b want=%b",
                         i, obs, mexp());
            end
            if (i == 1) soft_reset = 1'b0;
            if (rst_a) hi++;
        end
        total++;
        if (hi !== HOLD || loss_a !== 8'd0) begin
            bad++;
            $display("FAIL soft_hold got hi=%0d loss=%0d want %0d 0",
                     hi, loss_a, HOLD);
        end
    endtask

    task automatic test_simul();
        apply_reset(1'b1);
        for (int r = 0; r < 5; r++) begin
            run_to_ready();
            pll_lock = 1'b0;
            repeat (2) @(negedge clock);
            soft_reset = 1'b1;
            @(negedge clock);
            soft_reset = 1'b0;
            pll_lock   = 1'b1;
            total++;
            if (obs !== mexp() || !rst_a) begin
                bad++;
                $display("FAIL simul round=%0d got=%b want=%b",
                         r, obs, mexp());
            end
        end
        total++;
        if (loss_a !== 8'd5 || loss_b !== 2'd3) begin
            bad++;
            $display("FAIL simul_sat got a=%0d b=%0d want 5 3",
                     loss_a, loss_b);
        end
    endtask

    task automatic test_async();
        apply_reset(1'b1);
        run_to_ready();
        pll_lock = 1'b0;
        @(negedge clock);
        pll_lock = 1'b1;
        repeat (12) @(negedge clock);
        total++;
        if (obs !== mexp() || loss_a !== 8'd1) begin
            bad++;
            $display("FAIL async_pre got=%b want=%b", obs, mexp());
        end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (obs !== 14'b10_00000000_10_00) begin
            bad++;
            $display("FAIL async_hold got=%b want=%b",
                     obs, 14'b10_00000000_10_00);
        end
        @(negedge clock);
        reset_n = 1'b1;
        run_to_ready();
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (obs !== 14'b10_00000000_10_00) begin
            bad++;
            $display("FAIL async_run got=%b want=%b",
                     obs, 14'b10_00000000_10_00);
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_random();
        apply_reset(1'b1);
        for (int i = 0; i < 4000; i++) begin
            @(negedge clock);
            total++;
            if (obs !== mexp()) begin
                bad++;
                $display("FAIL random cyc=%0d got=%b want=%b",
                         i, obs, mexp());
            end
            pll_lock   = ($urandom_range(0, 149) != 0);
            soft_reset = ($urandom_range(0, 24) == 0);
        end
        soft_reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_glitch();
        test_loss();
        test_soft();
        test_simul();
        test_async();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
